// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and sampling constants for the oversampled UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int SAMPLES_PER_BIT = 16;
  localparam int SAMPLE_W        = $clog2(SAMPLES_PER_BIT);

  localparam logic [SAMPLE_W-1:0] VOTE_IDX_A      = SAMPLE_W'(7);
  localparam logic [SAMPLE_W-1:0] VOTE_IDX_B      = SAMPLE_W'(8);
  localparam logic [SAMPLE_W-1:0] VOTE_IDX_C      = SAMPLE_W'(9);
  localparam logic [SAMPLE_W-1:0] LAST_SAMPLE_IDX = SAMPLE_W'(SAMPLES_PER_BIT - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO with first-word-fall-through head
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == (AW + 1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with majority vote, error flags and FIFO
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          si_i,
  input  logic                          read_i,
  input  logic                          clear_err_i,
  output logic [DATA_BITS-1:0]          rx_data_o,
  output logic                          ninti_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overrun_o
);
  localparam int   TW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int   BW     = $clog2(DATA_BITS + 1);
  localparam logic ODD    = (PARITY_ODD != 0);

  rx_state_e             state_q;
  logic                  sync1_q, sync2_q, armed_q, vote_a_q, vote_b_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [SAMPLE_W-1:0]   sample_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  tick, decide, last_sample, bit_val, start_det;
  logic                  push, fifo_full, fifo_empty;
  logic                  frame_evt, parity_evt, overrun_evt;

  assign tick        = (tick_cnt_q == TW'(BAUD_DIV - 1));
  assign decide      = tick && (sample_q == VOTE_IDX_C);
  assign last_sample = tick && (sample_q == LAST_SAMPLE_IDX);
  assign bit_val     = majority3(vote_a_q, vote_b_q, sync2_q);
  assign start_det   = (state_q == ST_IDLE) && armed_q && !sync2_q;

  assign push        = (state_q == ST_STOP) && decide && bit_val;
  assign frame_evt   = (state_q == ST_STOP) && decide && !bit_val;
  assign parity_evt  = (state_q == ST_PARITY) && decide && ((^shift_q ^ bit_val) != ODD);
  assign overrun_evt = push && fifo_full && !read_i;
  assign ninti_o     = fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= si_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
      sample_q   <= '0;
      vote_a_q   <= 1'b0;
      vote_b_q   <= 1'b0;
    end else begin
      if (start_det) begin
        tick_cnt_q <= '0;
        sample_q   <= '0;
      end else if (tick) begin
        tick_cnt_q <= '0;
        sample_q   <= sample_q + 1'b1;
      end else begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      if (tick && sample_q == VOTE_IDX_A) vote_a_q <= sync2_q;
      if (tick && sample_q == VOTE_IDX_B) vote_b_q <= sync2_q;
    end
  end

  // Leaving STOP at the mid-bit vote leaves half a bit of margin to catch the next start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!armed_q) begin
            armed_q <= sync2_q;
          end else if (!sync2_q) begin
            armed_q <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (decide && bit_val) begin
            state_q <= ST_IDLE;
          end else if (last_sample) begin
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide) begin
            shift_q   <= {bit_val, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end else if (last_sample && bit_cnt_q == BW'(DATA_BITS)) begin
            state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: if (last_sample) state_q <= ST_STOP;
        ST_STOP:   if (decide) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o  <= frame_evt   | (frame_err_o  & ~clear_err_i);
      parity_err_o <= parity_evt  | (parity_err_o & ~clear_err_i);
      overrun_o    <= overrun_evt | (overrun_o    & ~clear_err_i);
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (read_i),
    .head_o  (rx_data_o),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;
  localparam int BIT_CLKS = 64;
  localparam int FRAME_BITS = 11;

  logic clk = 1'b0, rst_n = 1'b0, si = 1'b1, rd = 1'b0, clr = 1'b0;
  logic [7:0] rx_data;
  logic [2:0] level;
  logic ninti, ferr, perr, ovr;

  int checks = 0, errors = 0;
  logic [7:0] model_q[$];
  logic m_ferr = 1'b0, m_perr = 1'b0, m_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_oversampled #(
    .BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .si_i(si), .read_i(rd), .clear_err_i(clr),
    .rx_data_o(rx_data), .ninti_o(ninti), .level_o(level),
    .frame_err_o(ferr), .parity_err_o(perr), .overrun_o(ovr)
  );

  wire [6:0] obs_status = {level, ninti, ferr, perr, ovr};

  function automatic logic [6:0] exp_status();
    return {3'(model_q.size()), model_q.size() == 0, m_ferr, m_perr, m_ovr};
  endfunction

  task automatic idle(input int n);
    si = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; optionally pulses READ on the cycle the stop-bit write lands and checks NINTI timing.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                            input bit read_on_write, input bit check_timing);
    logic [10:0] bits;
    bits = {stop_bit, ^d ^ par_flip, d, 1'b0};
    for (int c = 0; c < FRAME_BITS * BIT_CLKS; c++) begin
      si = bits[c / BIT_CLKS];
      if (read_on_write) rd = (c == 682);
      @(negedge clk);
      if (check_timing && c + 1 == 682) begin
        checks++;
        if (ninti !== 1'b1) begin errors++; $display("FAIL ninti_before_write got %b exp 1", ninti); end
      end
      if (check_timing && c + 1 == 683) begin
        checks++;
        if (ninti !== 1'b0) begin errors++; $display("FAIL ninti_after_write got %b exp 0", ninti); end
      end
    end
    rd = 1'b0;
    if (read_on_write && model_q.size() > 0) void'(model_q.pop_front());
    if (par_flip) m_perr = 1'b1;
    if (!stop_bit) m_ferr = 1'b1;
    else if (model_q.size() < 4) model_q.push_back(d);
    else m_ovr = 1'b1;
  endtask

  task automatic do_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_status !== 7'b000_1_000) begin errors++; $display("FAIL reset_status got %b exp %b", obs_status, 7'b000_1_000); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(8);
    checks++;
    if (obs_status !== exp_status()) begin errors++; $display("FAIL basic_status got %b exp %b", obs_status, exp_status()); end
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", rx_data); end
    do_read();
    checks++;
    if (obs_status !== exp_status()) begin errors++; $display("FAIL basic_after_read got %b exp %b", obs_status, exp_status()); end
  endtask

  task automatic test_false_start();
    si = 1'b0;
    repeat (20) @(negedge clk);
    idle(100);
    checks++;
    if (obs_status !== exp_status()) begin errors++; $display("FAIL false_start got %b exp %b", obs_status, exp_status()); end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    si = 1'b0;
    repeat (200) @(negedge clk);
    idle(BIT_CLKS);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (obs_status !== exp_status()) begin errors++; $display("FAIL framing_status got %b exp %b", obs_status, exp_status()); end
    checks++;
    if (rx_data !== 8'h55) begin errors++; $display("FAIL framing_data got %h exp 55", rx_data); end
    do_read();
    do_clear();
  endtask

  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (obs_status !== exp_status()) begin errors++; $display("FAIL parity_status got %b exp %b", obs_status, exp_status()); end
    checks++;
    if (rx_data !== 8'h01) begin errors++; $display("FAIL parity_data got %h exp 01", rx_data); end
    do_clear();
    checks++;
    if (obs_status !== exp_status()) begin errors++; $display("FAIL parity_clear got %b exp %b", obs_status, exp_status()); end
    do_read();
  endtask

  task automatic test_overrun();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, (pass == 1) && (i == 4), 1'b0);
      idle(8);
      checks++;
      if (obs_status !== exp_status()) begin errors++; $display("FAIL overrun_status_%0d got %b exp %b", pass, obs_status, exp_status()); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_data !== model_q[0]) begin errors++; $display("FAIL overrun_read_%0d_%0d got %h exp %h", pass, i, rx_data, model_q[0]); end
        do_read();
      end
      do_clear();
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] bits;
    send_frame(8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    bits = {1'b1, 1'b0, 8'hF0, 1'b0};
    for (int c = 0; c < 4 * BIT_CLKS + 32; c++) begin
      si = bits[c / BIT_CLKS];
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    model_q.delete();
    m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    checks++;
    if (obs_status !== exp_status()) begin errors++; $display("FAIL midframe_reset_status got %b exp %b", obs_status, exp_status()); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL midframe_reset_data got %h exp 00", rx_data); end
    @(negedge clk);
    si = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (obs_status !== exp_status()) begin errors++; $display("FAIL after_reset_status got %b exp %b", obs_status, exp_status()); end
    checks++;
    if (rx_data !== 8'hC3) begin errors++; $display("FAIL after_reset_data got %h exp c3", rx_data); end
    do_read();
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int n = 0; n < 14; n++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom % 8) == 0, ($urandom % 8) != 0, ($urandom % 4) == 0, 1'b0);
      idle(10 + int'($urandom % 20));
      checks++;
      if (obs_status !== exp_status()) begin errors++; $display("FAIL random_status_%0d got %b exp %b", n, obs_status, exp_status()); end
      if (model_q.size() > 0) begin
        checks++;
        if (rx_data !== model_q[0]) begin errors++; $display("FAIL random_data_%0d got %h exp %h", n, rx_data, model_q[0]); end
      end
      if ($urandom % 2) do_read();
      if (($urandom % 5) == 0) do_clear();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_framing();
    test_parity();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Receiving end of the team's UART link: 16x-oversampled serial receiver with majority-vote sampling, optional parity check, framing/overrun detection and a small receive FIFO. It sits on the line driven by the transmitter (SO). It presents bytes to the host through a READ strobe and an active-low "data available" interrupt, NINTI. It replaces the simple single-sample receive path wherever noisy or asynchronous lines are expected.

Parameters:
BAUD_DIV, 27, Clock cycles per oversample tick (16 ticks = 1 bit time); minimum 2.
DATA_BITS, 8, data bits per frame, LSB first.
PARITY_EN, 1, 1 = one parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
FIFO_DEPTH, 4, receive FIFO entries; power of two.

Ports:
Clock  in  1  single system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
SI  in  1  serial input; idles high; asynchronous to Clock.
READ  in  1  one-cycle pop strobe for the FIFO head.
Clear_Err  in  1  clears all sticky error flags.
Rx_Data  out  DATA_BITS  FIFO head, first-word-fall-through.
NINTI  out  1  active-low; low while FIFO is non-empty.
Level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
Frame_Err  out  1  sticky; set when a stop bit is sampled as 0.
Parity_Err  out  1  sticky; set on parity mismatch.
Overrun  out  1  sticky; set when a byte is dropped because the FIFO is full.

Behaviour:
- Reset, asynchronous: state IDLE, unarmed; synchroniser flops = 1; counters = 0; FIFO empty; FIFO memory = 0; Rx_Data = 0; NINTI = 1; Level = 0; all error flags = 0. Reset mid-frame abandons the frame.
- SI passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Tick counter: counts 0..BAUD_DIV-1 and pulses a tick at BAUD_DIV-1. Sample counter: 0..15, advanced on each tick. Both counters clear when a start is detected.
- IDLE: arms only after seeing SI = 1. Once armed, SI = 0 moves to START with counters cleared.
- Per-bit decision: majority of the samples at ticks 7, 8 and 9, taken on tick 9.
  - START: majority 1 means a false start; return to IDLE with no error and no write. Majority 0 continues; at sample 15 go to DATA.
  - DATA: shift decided bits in LSB first. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: compare against the parity of the data bits using PARITY_ODD. A mismatch sets Parity_Err and the byte is still stored.
  - STOP: decided at sample 9; the FSM returns to IDLE (unarmed) in the same cycle, giving half-bit resync margin.
    - Stop = 1: write the byte to the FIFO on that cycle.
    - Stop = 0: discard the byte and set Frame_Err. IDLE re-arms only after SI returns high (break handling).
- FIFO write latency: write occurs on the tick-9 cycle of the stop bit. NINTI falls and Level increments on the next clock edge.
- READ while non-empty: pop; Rx_Data updates to the next entry the following cycle. READ while empty: ignored.
- Write while full without a same-cycle READ: byte dropped, Overrun set, FIFO unchanged.
- Write and READ in the same cycle: both performed, Level unchanged, no Overrun (including when full).
- Pointers wrap modulo FIFO_DEPTH. Level distinguishes full from empty using one extra bit.
- Clear_Err clears all three sticky flags. If a set event occurs in the same cycle, set wins.

Decomposition:
- Package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, PARITY, STOP);
  - SAMPLES_PER_BIT = 16;
  - vote sample indices 7/8/9;
  - the last-sample index 15.
- One sub-module: uart_rx_fifo, a synchronous FIFO with FWFT head, push, pop, level and full/empty outputs. The FSM, synchroniser and tick generator stay in the top module.

Test Plan:
Bench uses BAUD_DIV = 4, so one bit = 64 clocks.
1. Frame 0xA5, parity bit 0 (even), stop 1 -> NINTI low one cycle after stop-bit sample 9; Rx_Data = 0xA5, Level = 1, no errors. A READ pulse then gives NINTI = 1 and Level = 0.
2. SI low for 20 clocks, then high -> false start rejected; Level = 0, NINTI = 1, no flags.
3. Frame 0x3C with stop = 0, SI held low 200 clocks, then high, then a good 0x55 frame -> Frame_Err = 1. 0x3C is not stored; 0x55 is received, Level = 1.
4. Frame 0x01 with parity bit 0 (even expects 1) -> Parity_Err = 1, Rx_Data = 0x01 stored. Clear_Err pulse -> Parity_Err = 0.
5. Five back-to-back frames 0x10..0x14 with no READ -> Level = 4, Overrun = 1, reads return 0x10..0x13 in order. Repeat with READ asserted on the 5th write cycle -> Overrun stays 0 and 0x14 is retained.
6. Reset pulsed during data bit 3 of a frame -> all outputs at reset values immediately. The next complete frame 0xC3 is received correctly.
